// File: rtl/axis_fifo_pkg.sv
// Shared types and default widths for the AXI-Stream BRAM FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package axis_fifo_pkg;

  // Output register stage: either holding a beat for the consumer or not.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 64;

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port block RAM: port A writes, port B reads with a registered output.
// Latency: read data appears on dob one clock after enb; dob holds while enb is low.
// Backpressure: none; the caller controls when each port is enabled.
module bram_sdp #(
  parameter int BRAM_DATA_BIT_WIDTH = 33,
  parameter int BRAM_DEPTH          = 64
) (
  input  logic                            clk,
  input  logic                            ena,
  input  logic                            wea,
  input  logic [$clog2(BRAM_DEPTH)-1:0]   addra,
  input  logic [BRAM_DATA_BIT_WIDTH-1:0]  dia,
  input  logic                            enb,
  input  logic [$clog2(BRAM_DEPTH)-1:0]   addrb,
  output logic [BRAM_DATA_BIT_WIDTH-1:0]  dob
);

  logic [BRAM_DATA_BIT_WIDTH-1:0] mem [BRAM_DEPTH];

  // Write port: store the entry when both enable and write-enable are set.
  always_ff @(posedge clk) begin
    if (ena && wea) begin
      mem[addra] <= dia;
    end
  end

  // Read port: registered output, updated only on enb so the last beat stays put.
  always_ff @(posedge clk) begin
    if (enb) begin
      dob <= mem[addrb];
    end
  end

endmodule

// File: rtl/axis_bram_fifo_ctrl.sv
// AXI-Stream first-word-fall-through FIFO over one BRAM plus the BRAM output register.
// Latency: a beat written into an empty FIFO is presented two cycles later; 1 beat/cycle sustained.
// Backpressure: s_axis_tready drops when the BRAM holds DEPTH entries; output holds until m_axis_tready.
module axis_bram_fifo_ctrl
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(DEPTH+2)-1:0]    fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = $clog2(DEPTH + 2);
  localparam int EW = DATA_WIDTH + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] mem_count;
  logic [CW-1:0] mem_count_d;
  logic          rst_n_q;
  logic          wr_fire;
  logic          rd_issue;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;
  out_state_e    state_q;
  out_state_e    state_d;

  // Ready only depends on registers: the BRAM must have a free slot now,
  // a read in the same cycle does not open one up for this write.
  assign s_axis_tready = rst_n_q & (mem_count != CW'(DEPTH));
  assign wr_fire       = s_axis_tvalid & s_axis_tready;

  // A read is launched whenever a committed entry exists and the output
  // register is empty or being emptied this cycle.
  assign m_axis_tvalid = (state_q == OUT_VALID);
  assign rd_issue      = (mem_count != '0) & (~m_axis_tvalid | m_axis_tready);

  // Entry layout in the BRAM: end-of-packet flag above the data word.
  assign wr_entry                     = {s_axis_tlast, s_axis_tdata};
  assign {m_axis_tlast, m_axis_tdata} = rd_entry;

  assign fill_level = FW'(mem_count) + FW'(m_axis_tvalid);

  bram_sdp #(
    .BRAM_DATA_BIT_WIDTH (EW),
    .BRAM_DEPTH          (DEPTH)
  ) u_bram (
    .clk   (clk),
    .ena   (wr_fire),
    .wea   (wr_fire),
    .addra (wr_ptr),
    .dia   (wr_entry),
    .enb   (rd_issue),
    .addrb (rd_ptr),
    .dob   (rd_entry)
  );

  // Occupancy of the BRAM alone; a simultaneous write and read cancel out.
  always_comb begin
    mem_count_d = mem_count;
    if (wr_fire && !rd_issue) begin
      mem_count_d = mem_count + CW'(1);
    end else if (!wr_fire && rd_issue) begin
      mem_count_d = mem_count - CW'(1);
    end
  end

  // Output stage next state: a read launch always fills the register,
  // otherwise an accepted beat empties it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: begin
        if (rd_issue) begin
          state_d = OUT_VALID;
        end
      end
      OUT_VALID: begin
        if (!rd_issue && m_axis_tready) begin
          state_d = OUT_EMPTY;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  // Pointers, occupancy, output state and the delayed reset that gates ready.
  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      state_q   <= OUT_EMPTY;
      rst_n_q   <= 1'b0;
    end else begin
      rst_n_q   <= 1'b1;
      mem_count <= mem_count_d;
      state_q   <= state_d;
      if (wr_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_bram_fifo_ctrl.sv
module tb_axis_bram_fifo_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int FW    = $clog2(DEPTH + 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [FW-1:0] fill_level;

  int total = 0;
  int bad = 0;
  int delivered = 0;
  int max_fill = 0;

  // Reference model: the ordered list of beats accepted but not yet delivered.
  logic [DW:0] exp_q[$];

  logic        mon_stall_prev = 1'b0;
  logic        mon_rst_prev = 1'b0;
  logic [DW:0] mon_stall_dat = '0;

  axis_bram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .fill_level    (fill_level)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // One clock cycle: record an input handshake in the model, then advance past the edge.
  task automatic step(output bit fired);
    @(negedge clk);
    #1;
    fired = rst_n && s_tvalid && s_tready;
    if (fired) exp_q.push_back({s_tlast, s_tdata});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    bit f;
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(f);
      n++;
    end
    step(f);
    check("drain_complete", exp_q.size(), 0);
  endtask

  // Monitor: compares every delivered beat and the visible state against the model.
  initial begin
    logic [DW:0] got;
    logic [DW:0] want;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_stall_prev = 1'b0;
        mon_rst_prev = 1'b0;
      end else begin
        got = {m_tlast, m_tdata};
        check("fill_level", fill_level, exp_q.size());
        if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
        if (mon_rst_prev) begin
          if (exp_q.size() < DEPTH) check("s_tready_room", s_tready, 1);
          else if (exp_q.size() == DEPTH + 1) check("s_tready_full", s_tready, 0);
        end
        if (mon_stall_prev) begin
          check("hold_valid", m_tvalid, 1);
          check("hold_data", got, mon_stall_dat);
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", got, 0);
            check("unexpected_beat_count", 1, 0);
          end else begin
            want = exp_q.pop_front();
            check("beat", got, want);
          end
          delivered++;
        end
        mon_stall_prev = m_tvalid && !m_tready;
        mon_stall_dat = got;
        mon_rst_prev = 1'b1;
      end
    end
  end

  initial begin
    bit f;
    int acc;
    int d0;
    int cycles;

    // Reset state and release
    rst_n = 1'b0;
    repeat (3) step(f);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_fill", fill_level, 0);
    rst_n = 1'b1;
    step(f);
    check("release_s_tready", s_tready, 1);

    // Single beat latency
    m_tready = 1'b1;
    s_tdata = 32'hDEADBEEF;
    s_tlast = 1'b1;
    s_tvalid = 1'b1;
    step(f);
    check("lat_accept", f, 1);
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    check("lat_not_early", m_tvalid, 0);
    step(f);
    check("lat_valid_t2", m_tvalid, 1);
    check("lat_data", m_tdata, 32'hDEADBEEF);
    check("lat_last", m_tlast, 1);
    step(f);
    check("lat_fill_t3", fill_level, 0);

    // Fill to capacity with the consumer stalled
    m_tready = 1'b0;
    acc = 0;
    d0 = delivered;
    s_tvalid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      s_tdata = acc;
      s_tlast = (acc == 9);
      step(f);
      if (f) acc++;
    end
    s_tvalid = 1'b0;
    check("full_accepted", acc, DEPTH + 1);
    check("full_s_tready", s_tready, 0);
    check("full_fill", fill_level, DEPTH + 1);
    m_tready = 1'b1;
    drain(50);
    check("full_delivered", delivered - d0, DEPTH + 1);

    // Continuous streaming
    max_fill = 0;
    d0 = delivered;
    acc = 0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      s_tdata = $urandom;
      s_tlast = 1'($urandom_range(1));
      step(f);
      if (f) acc++;
    end
    s_tvalid = 1'b0;
    check("stream_accepted", acc, 1000);
    check("stream_delivered_inflight", delivered - d0, 998);
    drain(20);
    check("stream_delivered", delivered - d0, 1000);
    check("stream_max_fill_le2", max_fill <= 2, 1);

    // Random valid/ready with held beats on the input side
    acc = 0;
    cycles = 0;
    d0 = delivered;
    s_tvalid = 1'b0;
    while (acc < 10000 && cycles < 60000) begin
      if (!s_tvalid && $urandom_range(1) == 1) begin
        s_tvalid = 1'b1;
        s_tdata = $urandom;
        s_tlast = 1'($urandom_range(1));
      end
      m_tready = 1'($urandom_range(1));
      step(f);
      cycles++;
      if (f) begin
        acc++;
        s_tvalid = 1'b0;
      end
    end
    s_tvalid = 1'b0;
    check("rand_accepted", acc, 10000);
    m_tready = 1'b1;
    drain(50);
    check("rand_delivered", delivered - d0, 10000);

    // Reset while holding data
    m_tready = 1'b0;
    acc = 0;
    s_tvalid = 1'b1;
    for (int c = 0; c < 20 && acc < 5; c++) begin
      s_tdata = 32'h5000_0000 + acc;
      s_tlast = 1'b0;
      step(f);
      if (f) acc++;
    end
    s_tvalid = 1'b0;
    check("mid_fill5", fill_level, 5);
    rst_n = 1'b0;
    exp_q.delete();
    step(f);
    rst_n = 1'b1;
    check("mid_rst_m_tvalid", m_tvalid, 0);
    check("mid_rst_fill", fill_level, 0);
    step(f);
    m_tready = 1'b1;
    d0 = delivered;
    acc = 0;
    s_tvalid = 1'b1;
    for (int c = 0; c < 20 && acc < 3; c++) begin
      s_tdata = 32'hA000_0000 + acc;
      s_tlast = (acc == 2);
      step(f);
      if (f) acc++;
    end
    s_tvalid = 1'b0;
    drain(20);
    check("mid_post_delivered", delivered - d0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
